write_burst_feeder: RTL and testbench

// - Device-side stage directly upstream of the AXI write master. Buffers device write data in a local FIFO,

---
 rtl/write_burst_feeder.sv | 262 ++++++++++++++++++++++++++
 tb/tb_write_burst_feeder.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/write_burst_feeder.sv
// write_burst_feeder: buffers device write data and replays one burst request as single-cycle
//   memoryWrite strobes, each followed by GAP_CYCLES idle cycles so edge-detect capture sees every beat.
// Latency: request accepted in cycle T -> first strobe in cycle T+2 when data is present, then one beat
//   every GAP_CYCLES+1 cycles. Backpressure: req_ready only in IDLE; an empty FIFO stalls the burst in WAIT;
//   a push into a full FIFO is dropped unless a pop happens in the same cycle.
// Ports: devclock/ARESETn (sync, active-low); wr_push/wr_data/wr_full/wr_count data FIFO side;
//   req_* burst request in, req_ready/req_err/burst_done handshake out; memoryWrite/Datain plus the
//   ID/WADDR/WLEN/WSIZE/WBURST/WLOCK/WCACHE/WPROT header toward the AXI write master.
// Build option: define REQ_CHK_EN to reject INCR bursts crossing a 4 KB boundary and WRAP bursts with
//   an illegal length; without it every request is accepted and req_err stays 0.

module write_burst_feeder_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 16
) (
  input  logic                   devclock,
  input  logic                   ARESETn,
  input  logic                   push_i,
  input  logic [W-1:0]           dat_i,
  input  logic                   pop_i,
  output logic [W-1:0]           dat_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic          push_ok;
  logic          pop_ok;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign pop_ok  = pop_i && (count_q != '0);
  // A pop in the same cycle frees the head slot, so a push at full is still taken.
  assign push_ok = push_i && (!full_o || pop_ok);
  assign dat_o   = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_ff @(posedge devclock) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= dat_i;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge devclock) begin
    if (!ARESETn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

module write_burst_feeder #(
  parameter int BUSWIDTH   = 32,
  parameter int FIFO_DEPTH = 16,
  parameter int GAP_CYCLES = 1
) (
  input  logic                         devclock,
  input  logic                         ARESETn,
  input  logic                         wr_push,
  input  logic [BUSWIDTH-1:0]          wr_data,
  output logic                         wr_full,
  output logic [$clog2(FIFO_DEPTH):0]  wr_count,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [3:0]                   req_id,
  input  logic [31:0]                  req_addr,
  input  logic [3:0]                   req_len,
  input  logic [1:0]                   req_burst,
  input  logic [2:0]                   req_prot,
  output logic                         burst_done,
  output logic                         req_err,
  output logic                         memoryWrite,
  output logic [BUSWIDTH-1:0]          Datain,
  output logic [3:0]                   ID,
  output logic [31:0]                  WADDR,
  output logic [3:0]                   WLEN,
  output logic [2:0]                   WSIZE,
  output logic [1:0]                   WBURST,
  output logic [1:0]                   WLOCK,
  output logic [3:0]                   WCACHE,
  output logic [2:0]                   WPROT
);
  localparam int          GW      = $clog2(GAP_CYCLES + 1);
  localparam logic [2:0]  WSIZE_C = 3'($clog2(BUSWIDTH / 8));

  typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_WAIT, ST_STROBE, ST_GAP, ST_DONE} state_t;

  state_t                state_q, state_d;
  logic [4:0]            beat_q, beat_d;
  logic [GW-1:0]         gap_q, gap_d;
  logic [3:0]            id_q, id_d;
  logic [31:0]           addr_q, addr_d;
  logic [3:0]            len_q, len_d;
  logic [1:0]            burst_q, burst_d;
  logic [2:0]            prot_q, prot_d;
  logic                  mw_q, mw_d;
  logic [BUSWIDTH-1:0]   dat_q, dat_d;
  logic                  done_q, done_d;
  logic                  ready_q, ready_d;
  logic                  pop;
  logic                  req_bad;
  logic [BUSWIDTH-1:0]   fifo_dat;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic                  fifo_has_data;

  write_burst_feeder_fifo #(
    .W     (BUSWIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .devclock (devclock),
    .ARESETn  (ARESETn),
    .push_i   (wr_push),
    .dat_i    (wr_data),
    .pop_i    (pop),
    .dat_o    (fifo_dat),
    .count_o  (fifo_count),
    .full_o   (wr_full)
  );

  assign wr_count      = fifo_count;
  assign fifo_has_data = (fifo_count != '0);

`ifdef REQ_CHK_EN
  logic [31:0] span;
  logic        err_q, err_d;

  // Bytes touched from the start of the 4 KB page up to the end of the burst.
  assign span    = 32'(req_addr[11:0]) + (32'(req_len) + 32'd1) * 32'(BUSWIDTH / 8);
  assign req_bad = ((req_burst == 2'b01) && (span > 32'd4096)) ||
                   ((req_burst == 2'b10) && !(req_len inside {4'd1, 4'd3, 4'd7, 4'd15}));
  assign err_d   = (state_q == ST_IDLE) && req_valid && req_bad;
  assign req_err = err_q;

  always_ff @(posedge devclock) begin
    if (!ARESETn) err_q <= 1'b0;
    else          err_q <= err_d;
  end
`else
  assign req_bad = 1'b0;
  assign req_err = 1'b0;
`endif

  // pop marks every transition into STROBE: the FIFO head is captured into Datain on that
  // edge so memoryWrite and its data appear together for exactly the STROBE cycle.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    gap_d   = gap_q;
    id_d    = id_q;
    addr_d  = addr_q;
    len_d   = len_q;
    burst_d = burst_q;
    prot_d  = prot_q;
    done_d  = 1'b0;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid && !req_bad) begin
          id_d    = req_id;
          addr_d  = req_addr;
          len_d   = req_len;
          burst_d = req_burst;
          prot_d  = req_prot;
          beat_d  = '0;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD, ST_WAIT: begin
        if (fifo_has_data) begin
          pop     = 1'b1;
          state_d = ST_STROBE;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_STROBE: begin
        gap_d   = '0;
        state_d = ST_GAP;
      end
      ST_GAP: begin
        if (gap_q == GW'(GAP_CYCLES - 1)) begin
          if (beat_q == ({1'b0, len_q} + 5'd1)) begin
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else if (fifo_has_data) begin
            pop     = 1'b1;
            state_d = ST_STROBE;
          end else begin
            state_d = ST_WAIT;
          end
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (pop) begin
      beat_d = beat_q + 5'd1;
    end
  end

  assign mw_d    = pop;
  assign dat_d   = pop ? fifo_dat : dat_q;
  assign ready_d = (state_d == ST_IDLE);

  always_ff @(posedge devclock) begin
    if (!ARESETn) begin
      state_q <= ST_IDLE;
      beat_q  <= '0;
      gap_q   <= '0;
      id_q    <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      burst_q <= '0;
      prot_q  <= '0;
      mw_q    <= 1'b0;
      dat_q   <= '0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      gap_q   <= gap_d;
      id_q    <= id_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      burst_q <= burst_d;
      prot_q  <= prot_d;
      mw_q    <= mw_d;
      dat_q   <= dat_d;
      done_q  <= done_d;
      ready_q <= ready_d;
    end
  end

  assign req_ready   = ready_q;
  assign burst_done  = done_q;
  assign memoryWrite = mw_q;
  assign Datain      = dat_q;
  assign ID          = id_q;
  assign WADDR       = addr_q;
  assign WLEN        = len_q;
  assign WSIZE       = WSIZE_C;
  assign WBURST      = burst_q;
  assign WLOCK       = 2'b00;
  assign WCACHE      = 4'b0000;
  assign WPROT       = prot_q;
endmodule

// File: tb/tb_write_burst_feeder.sv
module tb_write_burst_feeder;
  logic        devclock = 1'b0;
  logic        ARESETn  = 1'b0;
  logic        wr_push  = 1'b0;
  logic [31:0] wr_data  = '0;
  logic        wr_full;
  logic [4:0]  wr_count;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_id    = '0;
  logic [31:0] req_addr  = '0;
  logic [3:0]  req_len   = '0;
  logic [1:0]  req_burst = '0;
  logic [2:0]  req_prot  = '0;
  logic        burst_done, req_err, memoryWrite;
  logic [31:0] Datain, WADDR;
  logic [3:0]  ID, WLEN, WCACHE;
  logic [2:0]  WSIZE, WPROT;
  logic [1:0]  WBURST, WLOCK;

  write_burst_feeder dut (
    .devclock(devclock), .ARESETn(ARESETn), .wr_push(wr_push), .wr_data(wr_data),
    .wr_full(wr_full), .wr_count(wr_count), .req_valid(req_valid), .req_ready(req_ready),
    .req_id(req_id), .req_addr(req_addr), .req_len(req_len), .req_burst(req_burst),
    .req_prot(req_prot), .burst_done(burst_done), .req_err(req_err), .memoryWrite(memoryWrite),
    .Datain(Datain), .ID(ID), .WADDR(WADDR), .WLEN(WLEN), .WSIZE(WSIZE), .WBURST(WBURST),
    .WLOCK(WLOCK), .WCACHE(WCACHE), .WPROT(WPROT)
  );

  always #5 devclock = ~devclock;

  int cyc = 0;
  always @(posedge devclock) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] dat;
    logic [3:0]  id;
    logic [31:0] addr;
    logic [3:0]  len;
    logic [1:0]  burst;
    logic [2:0]  prot;
    int          cyc;
  } beat_t;
  typedef struct {
    logic [3:0] id;
    int         cyc;
  } done_t;

  beat_t sb_q[$];
  done_t done_q[$];
  int checks = 0, errors = 0;
  int n_strobe = 0, n_done = 0, n_err = 0, done_target = 0;
  logic prev_mw = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic exp_beat(input logic [31:0] d, input logic [3:0] id, input logic [31:0] addr,
                          input logic [3:0] len, input logic [1:0] burst, input logic [2:0] prot,
                          input int c);
    sb_q.push_back('{dat: d, id: id, addr: addr, len: len, burst: burst, prot: prot, cyc: c});
  endtask

  task automatic exp_done(input logic [3:0] id, input int c);
    done_q.push_back('{id: id, cyc: c});
    done_target++;
  endtask

  // Scoreboard monitor: samples on the falling edge, pops expectations as outputs appear.
  always @(negedge devclock) begin
    beat_t e;
    done_t d;
    if (memoryWrite) begin
      n_strobe++;
      chk("strobe_not_back_to_back", prev_mw, 1'b0);
      chk("strobe_expected", sb_q.size() > 0, 1'b1);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("Datain", Datain, e.dat);
        chk("ID", ID, e.id);
        chk("WADDR", WADDR, e.addr);
        chk("WLEN", WLEN, e.len);
        chk("WBURST", WBURST, e.burst);
        chk("WPROT", WPROT, e.prot);
        chk("WLOCK_WCACHE", {WLOCK, WCACHE}, 6'd0);
        if (e.cyc >= 0) chk("strobe_cycle", cyc, e.cyc);
      end
    end
    if (burst_done) begin
      n_done++;
      chk("done_expected", done_q.size() > 0, 1'b1);
      if (done_q.size() > 0) begin
        d = done_q.pop_front();
        chk("done_ID", ID, d.id);
        if (d.cyc >= 0) chk("done_cycle", cyc, d.cyc);
      end
    end
    if (req_err) n_err++;
    prev_mw = memoryWrite;
  end

  task automatic do_reset();
    ARESETn = 1'b0;
    repeat (2) @(posedge devclock);
    #1;
    ARESETn = 1'b1;
  endtask

  task automatic push_word(input logic [31:0] d);
    wr_push = 1'b1;
    wr_data = d;
    @(posedge devclock); #1;
    wr_push = 1'b0;
  endtask

  task automatic do_req(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                        input logic [1:0] burst, input logic [2:0] prot, output int acc);
    chk("req_ready_before_req", req_ready, 1'b1);
    req_valid = 1'b1; req_id = id; req_addr = addr; req_len = len;
    req_burst = burst; req_prot = prot;
    @(posedge devclock); #1;
    acc = cyc;
    req_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (n_done < done_target && n < budget) begin
      @(posedge devclock); #1;
      n++;
    end
    chk("burst_done_within_budget", n_done >= done_target, 1'b1);
  endtask

  task automatic wait_ready(input int budget);
    int n = 0;
    while (!req_ready && n < budget) begin
      @(posedge devclock); #1;
      n++;
    end
    chk("req_ready_within_budget", req_ready, 1'b1);
  endtask

  initial begin
    int acc, acc2, base, dbase;

    // Reset state
    do_reset();
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_memoryWrite", memoryWrite, 1'b0);
    chk("rst_done_err", {burst_done, req_err}, 2'b00);
    chk("rst_wr_count", wr_count, 5'd0);
    chk("rst_wr_full", wr_full, 1'b0);
    chk("rst_header", {ID, WADDR, WLEN, WBURST, WPROT}, '0);
    chk("rst_Datain", Datain, 32'd0);
    chk("WSIZE", WSIZE, 3'd2);

    // 4-beat burst, data present: strobes 2 cycles apart starting T+2
    for (int i = 0; i < 4; i++) push_word(32'hA0A0_0000 + i);
    chk("count_after_4_pushes", wr_count, 5'd4);
    do_req(4'd5, 32'h100, 4'd3, 2'b01, 3'b010, acc);
    for (int k = 0; k < 4; k++) exp_beat(32'hA0A0_0000 + k, 4'd5, 32'h100, 4'd3, 2'b01, 3'b010, acc + 1 + 2*k);
    exp_done(4'd5, acc + 9);
    wait_done(40);
    chk("t1_sb_drained", sb_q.size(), 0);
    chk("t1_count_empty", wr_count, 5'd0);
    chk("t1_ready_after_done", req_ready, 1'b1);

    // Underrun: request first, data trickles in every 5 cycles
    base = n_strobe;
    do_req(4'd7, 32'h200, 4'd2, 2'b01, 3'b000, acc);
    for (int k = 0; k < 3; k++) exp_beat(32'hD0D0_0000 + k, 4'd7, 32'h200, 4'd2, 2'b01, 3'b000, -1);
    exp_done(4'd7, -1);
    for (int k = 0; k < 3; k++) begin
      repeat (4) begin @(posedge devclock); #1; end
      push_word(32'hD0D0_0000 + k);
    end
    wait_done(40);
    chk("t2_strobe_count", n_strobe - base, 3);
    chk("t2_sb_drained", sb_q.size(), 0);

    // Back-to-back requests, len 0 then len 1
    for (int i = 0; i < 3; i++) push_word(32'hE0E0_0000 + i);
    do_req(4'd1, 32'h300, 4'd0, 2'b01, 3'b001, acc);
    exp_beat(32'hE0E0_0000, 4'd1, 32'h300, 4'd0, 2'b01, 3'b001, acc + 1);
    exp_done(4'd1, acc + 3);
    wait_ready(20);
    do_req(4'd2, 32'h340, 4'd1, 2'b01, 3'b001, acc2);
    chk("b2b_accept_cycle", acc2, acc + 5);
    exp_beat(32'hE0E0_0001, 4'd2, 32'h340, 4'd1, 2'b01, 3'b001, acc2 + 1);
    exp_beat(32'hE0E0_0002, 4'd2, 32'h340, 4'd1, 2'b01, 3'b001, acc2 + 3);
    exp_done(4'd2, acc2 + 5);
    wait_done(40);
    chk("t6_sb_drained", sb_q.size(), 0);

    // 4 KB boundary check
    for (int i = 0; i < 4; i++) push_word(32'h6060_0000 + i);
`ifdef REQ_CHK_EN
    base = n_strobe;
    do_req(4'd4, 32'hFF8, 4'd3, 2'b01, 3'b000, acc);
    chk("reject_req_err", req_err, 1'b1);
    chk("reject_ready", req_ready, 1'b1);
    repeat (6) begin @(posedge devclock); #1; end
    chk("reject_no_strobe", n_strobe - base, 0);
    chk("reject_err_pulses", n_err, 1);
`else
    do_req(4'd4, 32'hFF8, 4'd3, 2'b01, 3'b000, acc);
    chk("nochk_req_err", req_err, 1'b0);
    for (int k = 0; k < 4; k++) exp_beat(32'h6060_0000 + k, 4'd4, 32'hFF8, 4'd3, 2'b01, 3'b000, acc + 1 + 2*k);
    exp_done(4'd4, acc + 9);
    wait_done(40);
    for (int i = 0; i < 4; i++) push_word(32'h6060_0000 + i);
`endif
    do_req(4'd4, 32'hFF0, 4'd3, 2'b01, 3'b000, acc);
    chk("ff0_req_err", req_err, 1'b0);
    for (int k = 0; k < 4; k++) exp_beat(32'h6060_0000 + k, 4'd4, 32'hFF0, 4'd3, 2'b01, 3'b000, acc + 1 + 2*k);
    exp_done(4'd4, acc + 9);
    wait_done(40);
    chk("t5_sb_drained", sb_q.size(), 0);

    // Full FIFO: 17th push dropped; push+pop at full keeps count
    do_reset();
    for (int i = 0; i < 16; i++) push_word(32'hC0C0_0000 + i);
    chk("full_count16", wr_count, 5'd16);
    chk("full_flag", wr_full, 1'b1);
    push_word(32'hDEAD_BEEF);
    chk("drop_count16", wr_count, 5'd16);
    do_req(4'd3, 32'h500, 4'd0, 2'b01, 3'b000, acc);
    exp_beat(32'hC0C0_0000, 4'd3, 32'h500, 4'd0, 2'b01, 3'b000, acc + 1);
    exp_done(4'd3, acc + 3);
    push_word(32'hC0DE_0010);
    chk("push_pop_full_count", wr_count, 5'd16);
    wait_done(20);
    chk("push_pop_full_flag", wr_full, 1'b1);
    do_req(4'd3, 32'h500, 4'd15, 2'b01, 3'b000, acc);
    for (int k = 0; k < 15; k++) exp_beat(32'hC0C0_0001 + k, 4'd3, 32'h500, 4'd15, 2'b01, 3'b000, acc + 1 + 2*k);
    exp_beat(32'hC0DE_0010, 4'd3, 32'h500, 4'd15, 2'b01, 3'b000, acc + 31);
    exp_done(4'd3, acc + 33);
    wait_done(60);
    chk("t3_count_empty", wr_count, 5'd0);
    chk("t3_sb_drained", sb_q.size(), 0);

    // Reset during a len=7 burst, right after the 2nd strobe
    for (int i = 0; i < 8; i++) push_word(32'hF0F0_0000 + i);
    dbase = n_done;
    do_req(4'd9, 32'h400, 4'd7, 2'b10, 3'b101, acc);
    exp_beat(32'hF0F0_0000, 4'd9, 32'h400, 4'd7, 2'b10, 3'b101, acc + 1);
    exp_beat(32'hF0F0_0001, 4'd9, 32'h400, 4'd7, 2'b10, 3'b101, acc + 3);
    while (cyc < acc + 3) begin @(posedge devclock); #1; end
    chk("mid_second_strobe", memoryWrite, 1'b1);
    ARESETn = 1'b0;
    @(posedge devclock); #1;
    chk("mid_rst_memoryWrite", memoryWrite, 1'b0);
    chk("mid_rst_req_ready", req_ready, 1'b1);
    chk("mid_rst_wr_count", wr_count, 5'd0);
    ARESETn = 1'b1;
    repeat (20) begin @(posedge devclock); #1; end
    chk("mid_rst_no_done", n_done - dbase, 0);
    chk("mid_rst_sb_drained", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
